// File: rtl/pipelined_control_unit.sv
// Control path for a 5-stage ARM-subset pipeline: Decode-stage decode, E/M/W control
// registers, NZCV flag register and condition evaluation. Optional counters: CTRL_PERF_CNT_EN.
module pipelined_control_unit #(
  parameter int ALUC_W   = 4,
  parameter int NUM_COND = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [31:0]       InstructionD,
  input  logic [3:0]        ALUFlagsE,
  input  logic              FlushE,
  output logic [1:0]        RegSrcD,
  output logic [1:0]        ImmSrcD,
  output logic              bx_mux_sel,
  output logic              ALUSrcE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [1:0]        shft_ctrl,
  output logic [4:0]        shamt,
  output logic              BranchTakenE,
  output logic              MemtoRegE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              MemtoRegW,
  output logic              RegWriteW,
  output logic              PCSrcW,
  output logic [1:0]        bl_mux_sel,
  output logic              PCWrPendingF
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       squash_cnt
`endif
);

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef struct packed {
    logic              regwrite;
    logic              memwrite;
    logic              memtoreg;
    logic              branch;
    logic              bl;
    logic              pcsrc;
    logic              flagwrite;
    logic              alusrc;
    logic [ALUC_W-1:0] alucontrol;
    logic [1:0]        shft_ctrl;
    logic [4:0]        shamt;
    logic [3:0]        cond;
  } e_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic memtoreg;
    logic pcsrc;
    logic bl;
  } m_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic pcsrc;
    logic bl;
  } w_ctrl_t;

  logic [1:0]        op_s;
  logic              is_bx_s;
  logic              regwrite_d_s;
  logic              memwrite_d_s;
  logic              memtoreg_d_s;
  logic              branch_d_s;
  logic              bl_d_s;
  logic              flagwrite_d_s;
  logic              alusrc_d_s;
  logic              pcsrc_d_s;
  logic              bx_d_s;
  logic [ALUC_W-1:0] alucontrol_d_s;
  logic [1:0]        shft_ctrl_d_s;
  logic [4:0]        shamt_d_s;
  logic [1:0]        regsrc_d_s;
  logic [1:0]        immsrc_d_s;
  logic              unused_instr_s;

  e_ctrl_t           e_d;
  e_ctrl_t           e_q;
  m_ctrl_t           m_d;
  m_ctrl_t           m_q;
  w_ctrl_t           w_d;
  w_ctrl_t           w_q;
  logic [3:0]        flags_d;
  logic [3:0]        flags_q;

  logic [NUM_COND-1:0] cond_table_s;
  logic              cond_ex_s;
  logic              branch_taken_s;
  logic              pcsrc_e_gated_s;

  assign op_s           = InstructionD[27:26];
  assign is_bx_s        = (InstructionD[27:4] == 24'h12FFF1);
  assign unused_instr_s = ^InstructionD[3:0];

  // Decode-stage instruction decode; BX is matched ahead of the data-processing class.
  always_comb begin
    regwrite_d_s   = 1'b0;
    memwrite_d_s   = 1'b0;
    memtoreg_d_s   = 1'b0;
    branch_d_s     = 1'b0;
    bl_d_s         = 1'b0;
    flagwrite_d_s  = 1'b0;
    alusrc_d_s     = 1'b0;
    bx_d_s         = 1'b0;
    alucontrol_d_s = '0;
    shft_ctrl_d_s  = 2'b00;
    shamt_d_s      = 5'd0;
    regsrc_d_s     = 2'b00;
    immsrc_d_s     = 2'b00;
    if (is_bx_s) begin
      bx_d_s         = 1'b1;
      branch_d_s     = 1'b1;
      alucontrol_d_s = ALUC_W'(4'b1101);
    end else begin
      case (op_s)
        2'b00: begin
          alucontrol_d_s = ALUC_W'(InstructionD[24:21]);
          alusrc_d_s     = InstructionD[25];
          regwrite_d_s   = (InstructionD[24:23] != 2'b10);
          flagwrite_d_s  = InstructionD[20];
          if (!InstructionD[25]) begin
            shft_ctrl_d_s = InstructionD[6:5];
            shamt_d_s     = InstructionD[11:7];
          end else begin
            shft_ctrl_d_s = 2'b00;
            shamt_d_s     = 5'd0;
          end
        end
        2'b01: begin
          alucontrol_d_s = InstructionD[23] ? ALUC_W'(4'b0100) : ALUC_W'(4'b0010);
          alusrc_d_s     = 1'b1;
          immsrc_d_s     = 2'b01;
          if (InstructionD[20]) begin
            memtoreg_d_s = 1'b1;
            regwrite_d_s = 1'b1;
          end else begin
            memwrite_d_s = 1'b1;
            regsrc_d_s   = 2'b10;
          end
        end
        2'b10: begin
          branch_d_s     = 1'b1;
          alusrc_d_s     = 1'b1;
          immsrc_d_s     = 2'b10;
          alucontrol_d_s = ALUC_W'(4'b0100);
          regsrc_d_s     = 2'b01;
          bl_d_s         = InstructionD[24];
          regwrite_d_s   = InstructionD[24];
        end
        default: begin
          regwrite_d_s = 1'b0;
        end
      endcase
    end
  end

  // BL writes R14, so its Rd field never redirects the PC through the W stage.
  assign pcsrc_d_s = regwrite_d_s & (InstructionD[15:12] == 4'd15) & ~bl_d_s;

  // Next E-stage contents: a bubble on flush, otherwise the decoded instruction.
  always_comb begin
    e_d = '0;
    if (FlushE) begin
      e_d = '0;
    end else begin
      e_d.regwrite   = regwrite_d_s;
      e_d.memwrite   = memwrite_d_s;
      e_d.memtoreg   = memtoreg_d_s;
      e_d.branch     = branch_d_s;
      e_d.bl         = bl_d_s;
      e_d.pcsrc      = pcsrc_d_s;
      e_d.flagwrite  = flagwrite_d_s;
      e_d.alusrc     = alusrc_d_s;
      e_d.alucontrol = alucontrol_d_s;
      e_d.shft_ctrl  = shft_ctrl_d_s;
      e_d.shamt      = shamt_d_s;
      e_d.cond       = InstructionD[31:28];
    end
  end

  // ARM condition table over the stored NZCV flags; NV (1111) never passes.
  always_comb begin
    cond_table_s          = '0;
    cond_table_s[COND_EQ] = flags_q[2];
    cond_table_s[COND_NE] = ~flags_q[2];
    cond_table_s[COND_CS] = flags_q[1];
    cond_table_s[COND_CC] = ~flags_q[1];
    cond_table_s[COND_MI] = flags_q[3];
    cond_table_s[COND_PL] = ~flags_q[3];
    cond_table_s[COND_VS] = flags_q[0];
    cond_table_s[COND_VC] = ~flags_q[0];
    cond_table_s[COND_HI] = flags_q[1] & ~flags_q[2];
    cond_table_s[COND_LS] = ~flags_q[1] | flags_q[2];
    cond_table_s[COND_GE] = (flags_q[3] == flags_q[0]);
    cond_table_s[COND_LT] = (flags_q[3] != flags_q[0]);
    cond_table_s[COND_GT] = ~flags_q[2] & (flags_q[3] == flags_q[0]);
    cond_table_s[COND_LE] = flags_q[2] | (flags_q[3] != flags_q[0]);
    cond_table_s[COND_AL] = 1'b1;
    cond_table_s[COND_NV] = 1'b0;
  end

  assign cond_ex_s       = cond_table_s[e_q.cond];
  assign branch_taken_s  = e_q.branch & cond_ex_s;
  assign pcsrc_e_gated_s = e_q.pcsrc & cond_ex_s;

  // E->M and M->W transfers plus the flag update; condition gating happens here.
  always_comb begin
    m_d.regwrite = e_q.regwrite & cond_ex_s;
    m_d.memwrite = e_q.memwrite & cond_ex_s;
    m_d.memtoreg = e_q.memtoreg;
    m_d.pcsrc    = pcsrc_e_gated_s;
    m_d.bl       = e_q.bl & cond_ex_s;
    w_d.regwrite = m_q.regwrite;
    w_d.memtoreg = m_q.memtoreg;
    w_d.pcsrc    = m_q.pcsrc;
    w_d.bl       = m_q.bl;
    if (e_q.flagwrite & cond_ex_s) begin
      flags_d = ALUFlagsE;
    end else begin
      flags_d = flags_q;
    end
  end

  // Pipeline and flag registers; rst clears everything, FlushE only the E stage.
  always_ff @(posedge clock) begin
    if (rst) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      flags_q <= 4'b0000;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= w_d;
      flags_q <= flags_d;
    end
  end

  assign RegSrcD      = regsrc_d_s;
  assign ImmSrcD      = immsrc_d_s;
  assign bx_mux_sel   = bx_d_s;
  assign ALUSrcE      = e_q.alusrc;
  assign ALUControlE  = e_q.alucontrol;
  assign shft_ctrl    = e_q.shft_ctrl;
  assign shamt        = e_q.shamt;
  assign BranchTakenE = branch_taken_s;
  assign MemtoRegE    = e_q.memtoreg;
  assign RegWriteM    = m_q.regwrite;
  assign MemWriteM    = m_q.memwrite;
  assign MemtoRegW    = w_q.memtoreg;
  assign RegWriteW    = w_q.regwrite;
  assign PCSrcW       = w_q.pcsrc;
  assign bl_mux_sel   = {w_q.bl, w_q.bl};
  assign PCWrPendingF = pcsrc_d_s | pcsrc_e_gated_s | m_q.pcsrc;

`ifdef CTRL_PERF_CNT_EN
  logic        br_taken_m_d;
  logic        br_taken_m_q;
  logic        memwrite_w_d;
  logic        memwrite_w_q;
  logic        br_taken_w_d;
  logic        br_taken_w_q;
  logic        e_nonnop_s;
  logic        retire_w_s;
  logic [1:0]  squash_inc_s;
  logic [31:0] retired_cnt_d;
  logic [31:0] retired_cnt_q;
  logic [31:0] squash_cnt_d;
  logic [31:0] squash_cnt_q;

  assign e_nonnop_s = e_q.regwrite | e_q.memwrite | e_q.memtoreg | e_q.branch | e_q.flagwrite;
  assign retire_w_s = w_q.regwrite | memwrite_w_q | br_taken_w_q;

  // Retire/squash bookkeeping; a flush and a failed condition in one cycle count twice.
  always_comb begin
    br_taken_m_d  = branch_taken_s;
    memwrite_w_d  = m_q.memwrite;
    br_taken_w_d  = br_taken_m_q;
    squash_inc_s  = {1'b0, FlushE} + {1'b0, e_nonnop_s & ~cond_ex_s};
    retired_cnt_d = retired_cnt_q + {31'd0, retire_w_s};
    squash_cnt_d  = squash_cnt_q + {30'd0, squash_inc_s};
  end

  // Counter registers; they wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (rst) begin
      br_taken_m_q  <= 1'b0;
      memwrite_w_q  <= 1'b0;
      br_taken_w_q  <= 1'b0;
      retired_cnt_q <= 32'd0;
      squash_cnt_q  <= 32'd0;
    end else begin
      br_taken_m_q  <= br_taken_m_d;
      memwrite_w_q  <= memwrite_w_d;
      br_taken_w_q  <= br_taken_w_d;
      retired_cnt_q <= retired_cnt_d;
      squash_cnt_q  <= squash_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign squash_cnt  = squash_cnt_q;
`endif

endmodule
